// File: rtl/firmware_pkg.sv
// Shared definitions for the firmware loading path: memory geometry, frame marker,
// loader FSM states and error codes.
package firmware_pkg;

  localparam int FIRMWARE_SIZE = 8192;
  localparam logic [7:0] SYNC_BYTE = 8'h5A;

  // Vector region sits at the bottom of firmware memory; application code follows it
  localparam logic [15:0] VECTOR_BASE  = 16'h0000;
  localparam logic [15:0] VECTOR_BYTES = 16'h0040;
  localparam logic [15:0] APP_BASE     = VECTOR_BASE + VECTOR_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR_LO = 3'd1,
    ST_ADDR_HI = 3'd2,
    ST_LEN_LO  = 3'd3,
    ST_LEN_HI  = 3'd4,
    ST_DATA    = 3'd5,
    ST_CSUM    = 3'd6
  } loader_state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_CSUM  = 2'd2;

  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/firmware_loader.sv
// Parses framed load commands from a byte stream and writes the payload into
// firmware memory while holding the CPU in reset.
module firmware_loader #(
  parameter int         FIRMWARE_SIZE = firmware_pkg::FIRMWARE_SIZE,
  parameter logic [7:0] SYNC_BYTE     = firmware_pkg::SYNC_BYTE,
  localparam int        AW            = $clog2(FIRMWARE_SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] wr_address,
  output logic [7:0]    wr_data,
  output logic          wr_en,
  output logic          cpu_hold,
  output logic          done,
  output logic [1:0]    err
);
  import firmware_pkg::*;

  localparam logic [16:0] FW_LIMIT = 17'(FIRMWARE_SIZE);

  loader_state_t state_r, state_s;
  logic [15:0]   addr_r, addr_s;
  logic [15:0]   len_r, len_s;
  logic [7:0]    sum_r, sum_s;
  logic [AW-1:0] wr_address_r, wr_address_s;
  logic [7:0]    wr_data_r, wr_data_s;
  logic          wr_en_r, wr_en_s;
  logic          cpu_hold_r, cpu_hold_s;
  logic          done_r, done_s;
  logic [1:0]    err_r, err_s;
  logic          in_ready_r;

  logic          accept_s;
  logic [15:0]   len_full_s;
  logic [16:0]   end_s;
  logic          range_bad_s;

  assign accept_s   = in_valid && in_ready_r;
  assign len_full_s = {in_data, len_r[7:0]};
  // 17-bit end offset so a start near 0xFFFF plus a large length cannot wrap
  assign end_s      = {1'b0, addr_r} + {1'b0, len_full_s};
  assign range_bad_s = (len_full_s == 16'd0) || ({1'b0, addr_r} >= FW_LIMIT) ||
                       (end_s > FW_LIMIT);

  // Next-state and next-output logic for the frame parser
  always_comb begin
    state_s      = state_r;
    addr_s       = addr_r;
    len_s        = len_r;
    sum_s        = sum_r;
    wr_address_s = wr_address_r;
    wr_data_s    = wr_data_r;
    wr_en_s      = 1'b0;
    cpu_hold_s   = cpu_hold_r;
    done_s       = 1'b0;
    err_s        = err_r;
    if (accept_s) begin
      case (state_r)
        ST_IDLE: begin
          if (in_data == SYNC_BYTE) begin
            state_s    = ST_ADDR_LO;
            err_s      = ERR_NONE;
            sum_s      = 8'h00;
            cpu_hold_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_ADDR_LO: begin
          addr_s  = {addr_r[15:8], in_data};
          state_s = ST_ADDR_HI;
        end
        ST_ADDR_HI: begin
          addr_s  = {in_data, addr_r[7:0]};
          state_s = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          len_s   = {len_r[15:8], in_data};
          state_s = ST_LEN_HI;
        end
        ST_LEN_HI: begin
          len_s = len_full_s;
          if (range_bad_s) begin
            err_s      = ERR_RANGE;
            cpu_hold_s = 1'b0;
            state_s    = ST_IDLE;
          end else begin
            state_s = ST_DATA;
          end
        end
        ST_DATA: begin
          wr_en_s      = 1'b1;
          wr_address_s = addr_r[AW-1:0];
          wr_data_s    = in_data;
          addr_s       = addr_r + 16'd1;
          len_s        = len_r - 16'd1;
          sum_s        = csum_add(sum_r, in_data);
          if (len_r == 16'd1) begin
            state_s = ST_CSUM;
          end else begin
            state_s = ST_DATA;
          end
        end
        ST_CSUM: begin
          cpu_hold_s = 1'b0;
          state_s    = ST_IDLE;
          if (csum_add(sum_r, in_data) == 8'h00) begin
            done_s = 1'b1;
          end else begin
            err_s = ERR_CSUM;
          end
        end
        default: begin
          state_s    = ST_IDLE;
          cpu_hold_s = 1'b0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and registered outputs; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      addr_r       <= 16'd0;
      len_r        <= 16'd0;
      sum_r        <= 8'h00;
      wr_address_r <= '0;
      wr_data_r    <= 8'h00;
      wr_en_r      <= 1'b0;
      cpu_hold_r   <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= ERR_NONE;
      in_ready_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      addr_r       <= addr_s;
      len_r        <= len_s;
      sum_r        <= sum_s;
      wr_address_r <= wr_address_s;
      wr_data_r    <= wr_data_s;
      wr_en_r      <= wr_en_s;
      cpu_hold_r   <= cpu_hold_s;
      done_r       <= done_s;
      err_r        <= err_s;
      in_ready_r   <= 1'b1;
    end
  end

  assign in_ready   = in_ready_r;
  assign wr_address = wr_address_r;
  assign wr_data    = wr_data_r;
  assign wr_en      = wr_en_r;
  assign cpu_hold   = cpu_hold_r;
  assign done       = done_r;
  assign err        = err_r;

endmodule

// File: tb/tb_firmware_loader.sv
// Scoreboard bench for firmware_loader: stimulus pushes expected writes and frame
// outcomes, a negedge monitor pops and compares them as the DUT produces them.
module tb_firmware_loader;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] wr_address;
  logic [7:0]    wr_data;
  logic          wr_en;
  logic          cpu_hold;
  logic          done;
  logic [1:0]    err;

  int total = 0;
  int bad = 0;

  logic [20:0] wq[$];   // {address, data}
  logic [2:0]  rq[$];   // {done, err} seen when cpu_hold falls
  logic        hold_prev = 1'b0;

  firmware_loader dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_address(wr_address), .wr_data(wr_data),
    .wr_en(wr_en), .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every write strobe and every frame end against the scoreboard
  always @(negedge clk) begin
    logic [20:0] w;
    logic [2:0]  r;
    if (wr_en) begin
      if (wq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: addr %0h data %0h with no write expected", wr_address, wr_data);
      end else begin
        w = wq.pop_front();
        chk("write", {11'd0, wr_address, wr_data}, {11'd0, w});
      end
    end
    if (hold_prev && !cpu_hold) begin
      if (rq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_frame_end: done %0b err %0d", done, err);
      end else begin
        r = rq.pop_front();
        chk("frame_result", {29'd0, done, err}, {29'd0, r});
      end
    end else if (done) begin
      total++; bad++;
      $display("FAIL stray_done: got 1 expected 0 (cpu_hold %0b)", cpu_hold);
    end
    hold_prev = cpu_hold;
  end

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic header(input logic [15:0] a, input logic [15:0] l);
    send(8'h5A);
    chk("cpu_hold_rise", {31'd0, cpu_hold}, 32'd1);
    chk("err_clear_on_sync", {30'd0, err}, 32'd0);
    send(a[7:0]); send(a[15:8]); send(l[7:0]); send(l[15:8]);
  endtask

  task automatic push_w(input logic [12:0] a, input logic [7:0] d);
    wq.push_back({a, d});
  endtask

  initial begin
    fork
      begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_outputs", {11'd0, wr_en, wr_address, wr_data, cpu_hold, done, err},
        32'd0);
    rst_n = 1'b1;
    idle(2);
    chk("in_ready_up", {31'd0, in_ready}, 32'd1);

    // Good frame at 0: 11 22 33, checksum 0x9A
    push_w(13'h0000, 8'h11); push_w(13'h0001, 8'h22); push_w(13'h0002, 8'h33);
    rq.push_back({1'b1, 2'd0});
    header(16'h0000, 16'd3);
    send(8'h11); send(8'h22); send(8'h33); send(8'h9A);
    idle(2);

    // Same frame, bad checksum: writes happen, err=2, no done
    push_w(13'h0000, 8'h11); push_w(13'h0001, 8'h22); push_w(13'h0002, 8'h33);
    rq.push_back({1'b0, 2'd2});
    header(16'h0000, 16'd3);
    send(8'h11); send(8'h22); send(8'h33); send(8'h00);
    idle(2);
    chk("err_csum_sticky", {30'd0, err}, 32'd2);

    // 0x1FFE + 3 overruns memory
    rq.push_back({1'b0, 2'd1});
    header(16'h1FFE, 16'd3);
    chk("range_hold_drop", {31'd0, cpu_hold}, 32'd0);
    chk("range_err", {30'd0, err}, 32'd1);
    idle(2);

    // 0x1FFE + 2 fits exactly; a gap cycle mid-payload must hold state
    push_w(13'h1FFE, 8'hAA); push_w(13'h1FFF, 8'h55);
    rq.push_back({1'b0, 2'd1});
    rq.pop_back();
    rq.push_back({1'b1, 2'd0});
    header(16'h1FFE, 16'd2);
    send(8'hAA); idle(1); send(8'h55); send(8'h01);
    idle(2);

    // Start at the size boundary
    rq.push_back({1'b0, 2'd1});
    header(16'h2000, 16'd1);
    idle(2);

    // Zero length
    rq.push_back({1'b0, 2'd1});
    header(16'h0010, 16'd0);
    idle(2);
    chk("len0_err_sticky", {30'd0, err}, 32'd1);

    // Leading junk ignored; payload byte 0x5A is plain data
    send(8'h00); send(8'hFF);
    push_w(13'h0100, 8'h5A);
    rq.push_back({1'b1, 2'd0});
    header(16'h0100, 16'd1);
    send(8'h5A); send(8'hA6);
    idle(2);

    // Reset after the second data byte of a LEN=4 frame
    push_w(13'h0100, 8'hC1); push_w(13'h0101, 8'hC2);
    rq.push_back({1'b0, 2'd0});
    header(16'h0100, 16'd4);
    send(8'hC1); send(8'hC2);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midframe_rst_outputs", {10'd0, in_ready, wr_en, wr_address, wr_data, cpu_hold, done, err},
        32'd0);
    rst_n = 1'b1;
    idle(1);
    send(8'h33); send(8'h44); send(8'h9A);
    push_w(13'h0005, 8'h7E);
    rq.push_back({1'b1, 2'd0});
    header(16'h0005, 16'd1);
    send(8'h7E); send(8'h82);
    idle(4);

    chk("write_queue_empty", wq.size(), 32'd0);
    chk("result_queue_empty", rq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/firmware_loader.md
# firmware_loader

Serial-to-ROM writer for the 8 KiB firmware memory. It consumes a byte stream, such as the debug UART receiver output, parses a framed load command, and issues one-byte writes into firmware memory at a start offset. It holds the CPU in reset while a load is in progress and reports completion or an error. It sits between the host-link receiver and the write port of the firmware/vector memory.

## Interface
Parameters:
- `FIRMWARE_SIZE`, default 8192: bytes of firmware memory; `AW = $clog2(FIRMWARE_SIZE)`.
- `SYNC_BYTE`, default 8'h5A: frame start marker.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset, synchronous, active-low (already decided).
- `in_data`, input, 8: stream byte.
- `in_valid`, input, 1: `in_data` valid.
- `in_ready`, output, 1: loader accepts a byte this cycle.
- `wr_address`, output, AW: firmware memory byte offset.
- `wr_data`, output, 8: byte to write.
- `wr_en`, output, 1: single-cycle write strobe.
- `cpu_hold`, output, 1: hold CPU in reset while loading.
- `done`, output, 1: one-cycle pulse when a frame completes without error.
- `err`, output, 2: 0 = none, 1 = bad range, 2 = checksum mismatch. Sticky.

## Operation
- A byte is accepted when `in_valid && in_ready` on a rising edge. `in_ready` is 1 whenever `rst_n` is high.
- Frame format: `SYNC_BYTE`, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, then LEN data bytes, then CSUM.
- Checksum rule: the 8-bit sum of all data bytes plus CSUM must equal 0.
- States:
  - IDLE: bytes other than `SYNC_BYTE` are discarded. On sync, go to ADDR_LO, clear `err`, reset the running sum.
  - ADDR_LO, ADDR_HI: capture the 16-bit start address.
  - LEN_LO, LEN_HI: capture the 16-bit length.
  - DATA: each accepted byte causes a write at the current address, then address+1 and length−1. Leave for CSUM after the last byte.
  - CSUM: compare the checksum, then return to IDLE.
- Range check on LEN_HI acceptance, with 17-bit arithmetic: fail if LEN == 0, or if start ≥ FIRMWARE_SIZE, or if start+LEN > FIRMWARE_SIZE. On failure set `err`=1 and return to IDLE. No write ever wraps.
- On checksum mismatch: `err`=2 and no `done` pulse. Bytes already written stay in memory.
- A sync byte received mid-frame is treated as ordinary data. There is no resync until the frame ends.
- Reset values: state IDLE, `wr_en`=0, `wr_address`=0, `wr_data`=0, `cpu_hold`=0, `done`=0, `err`=0, `in_ready`=0.
- Reset mid-frame aborts the frame immediately, with all outputs at their reset values.

## Timing
- All outputs are registered.
- Write latency is 1 cycle: when a DATA byte is accepted on edge k, `wr_en`/`wr_address`/`wr_data` are valid in the cycle after edge k. Back-to-back accepted bytes produce back-to-back writes.
- `cpu_hold` rises the cycle after sync is accepted. It falls the cycle after CSUM is accepted, or the cycle after a range failure is detected.
- `done` pulses in the same cycle `cpu_hold` falls after a good checksum.
- `err` updates in the cycle after the offending byte and stays set until the next accepted sync.
- `in_valid` may be low in any cycle. The FSM holds its state and `wr_en` is 0 in those cycles.

## Structure
- Shared package `firmware_pkg`:
  - `FIRMWARE_SIZE`
  - the vector region layout
  - `SYNC_BYTE`
  - the state enum `loader_state_t`
  - the error codes `ERR_NONE`, `ERR_RANGE`, `ERR_CSUM`
- No sub-module is needed. The checksum accumulator is an 8-bit register inside this block.

## Test plan
- Load at 0x0000 with LEN=3, data 11 22 33, CSUM 0x9A -> writes (0,11), (1,22), (2,33) on consecutive cycles; `done` pulses once; `err`=0; `cpu_hold` high from the cycle after sync until the cycle after CSUM.
- Same frame with CSUM 0x00 -> three writes occur, no `done`, `err`=2.
- Start 0x1FFE with LEN=3 -> no writes, `err`=1, `cpu_hold` drops the cycle after LEN_HI is accepted. Start 0x1FFE with LEN=2 succeeds and writes addresses 0x1FFE and 0x1FFF.
- LEN=0 -> `err`=1. A following valid frame clears `err` on its sync and completes normally.
- Bytes 00 FF 5A sent before a frame -> the first two are ignored and the frame parses normally. A payload containing 0x5A is written as data.
- `rst_n` low for 1 cycle after the second data byte of a LEN=4 frame -> all outputs at reset values the next cycle, no further writes, and the next sync starts a fresh frame.
